// File: rtl/set_multi_circle_pkg.sv
// set_pkg: shared definitions for the multi-circle set counter.
//   - Mode encodings for the per-point set predicate.
//   - Scan FSM state type.
//   - cnt_width(): width needed to hold a count of 0..GRID*GRID.
package set_pkg;

  // Predicate select values; 3'd6 and 3'd7 are reserved and count nothing.
  localparam logic [2:0] MODE_A    = 3'd0;  // A
  localparam logic [2:0] MODE_AND  = 3'd1;  // A & B
  localparam logic [2:0] MODE_XOR  = 3'd2;  // A ^ B
  localparam logic [2:0] MODE_TWO  = 3'd3;  // exactly two of A, B, C
  localparam logic [2:0] MODE_AND3 = 3'd4;  // A & B & C
  localparam logic [2:0] MODE_OR3  = 3'd5;  // A | B | C

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // The count can reach GRID*GRID inclusive, hence the +1.
  function automatic int cnt_width(input int grid);
    return $clog2(grid * grid + 1);
  endfunction

endpackage

// File: rtl/set_multi_circle_if.sv
// set_multi_circle_if: job request / result bundle for set_multi_circle.
//   en        : job start (master -> slave), sampled only while busy=0
//   central   : {Ax,Ay,Bx,By,Cx,Cy}, CW bits each, MSB first
//   radius    : {rA,rB,rC}, CW bits each, MSB first
//   mode      : predicate select (see set_pkg MODE_*)
//   busy      : job in progress (slave -> master)
//   valid     : one-cycle result strobe
//   candidate : point count, held until the next result or reset
interface set_multi_circle_if #(
  parameter int GRID = 8,
  parameter int CW   = 4
);
  import set_pkg::*;

  localparam int CNT_W = cnt_width(GRID);

  logic             en;
  logic [6*CW-1:0]  central;
  logic [3*CW-1:0]  radius;
  logic [2:0]       mode;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] candidate;

  modport master (
    output en, central, radius, mode,
    input  busy, valid, candidate
  );

  modport slave (
    input  en, central, radius, mode,
    output busy, valid, candidate
  );

endinterface

// File: rtl/set_multi_circle_hit.sv
// set_circle_hit: combinational inclusive point-in-circle test.
//   i_px, i_py : lattice point
//   i_cx, i_cy : circle centre (may be off-grid)
//   i_r        : radius
//   o_in       : 1 when (px-cx)^2 + (py-cy)^2 <= r^2
// Everything is unsigned and sized so no intermediate result can wrap.
module set_circle_hit #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] i_px,
  input  logic [CW-1:0] i_py,
  input  logic [CW-1:0] i_cx,
  input  logic [CW-1:0] i_cy,
  input  logic [CW-1:0] i_r,
  output logic          o_in
);

  logic [CW-1:0]   w_dx;
  logic [CW-1:0]   w_dy;
  logic [2*CW-1:0] w_dx2;
  logic [2*CW-1:0] w_dy2;
  logic [2*CW-1:0] w_r2;
  logic [2*CW:0]   w_sum;

  // Absolute differences avoid signed arithmetic entirely.
  assign w_dx  = (i_px >= i_cx) ? (i_px - i_cx) : (i_cx - i_px);
  assign w_dy  = (i_py >= i_cy) ? (i_py - i_cy) : (i_cy - i_py);

  assign w_dx2 = {{CW{1'b0}}, w_dx} * {{CW{1'b0}}, w_dx};
  assign w_dy2 = {{CW{1'b0}}, w_dy} * {{CW{1'b0}}, w_dy};
  assign w_r2  = {{CW{1'b0}}, i_r}  * {{CW{1'b0}}, i_r};

  assign w_sum = {1'b0, w_dx2} + {1'b0, w_dy2};
  assign o_in  = (w_sum <= {1'b0, w_r2});

endmodule

// File: rtl/set_multi_circle.sv
// set_multi_circle: scans a GRID x GRID lattice (1..GRID per axis) one point
// per cycle and counts points satisfying a mode-selected predicate over three
// circles A, B, C.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : set_multi_circle_if slave (en/central/radius/mode in,
//          busy/valid/candidate out)
// A job captured in cycle T scans during T+1..T+GRID^2; valid pulses in
// T+GRID^2+1, when the FSM is already back in IDLE and can take a new en.
module set_multi_circle
  import set_pkg::*;
#(
  parameter int GRID = 8,
  parameter int CW   = 4
) (
  input logic                clk,
  input logic                rst,
  set_multi_circle_if.slave  bus
);

  localparam int            CNT_W = cnt_width(GRID);
  localparam logic [CW-1:0] LAST  = CW'(GRID);
  localparam logic [CW-1:0] FIRST = CW'(1);

  state_e           r_state;
  state_e           w_state_next;
  logic [6*CW-1:0]  r_central;
  logic [3*CW-1:0]  r_radius;
  logic [2:0]       r_mode;
  logic [CW-1:0]    r_x;
  logic [CW-1:0]    r_y;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_candidate;
  logic             r_valid;

  logic [2:0]       w_in;     // [0]=A, [1]=B, [2]=C
  logic             w_hit;
  logic             w_last;
  logic             w_start;

  // Three identical membership tests on the captured job parameters.
  for (genvar gi = 0; gi < 3; gi++) begin : g_circle
    set_circle_hit #(.CW(CW)) u_hit (
      .i_px (r_x),
      .i_py (r_y),
      .i_cx (r_central[6*CW-1 - 2*gi*CW -: CW]),
      .i_cy (r_central[5*CW-1 - 2*gi*CW -: CW]),
      .i_r  (r_radius[3*CW-1 - gi*CW -: CW]),
      .o_in (w_in[gi])
    );
  end

  always_comb begin
    w_hit = 1'b0;
    case (r_mode)
      MODE_A:    w_hit = w_in[0];
      MODE_AND:  w_hit = w_in[0] & w_in[1];
      MODE_XOR:  w_hit = w_in[0] ^ w_in[1];
      MODE_TWO:  w_hit = (w_in[0] & w_in[1] & ~w_in[2]) |
                         (w_in[0] & ~w_in[1] & w_in[2]) |
                         (~w_in[0] & w_in[1] & w_in[2]);
      MODE_AND3: w_hit = &w_in;
      MODE_OR3:  w_hit = |w_in;
      default:   w_hit = 1'b0;
    endcase
  end

  assign w_last  = (r_x == LAST) && (r_y == LAST);
  assign w_start = (r_state == IDLE) && bus.en;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.en) w_state_next = SCAN;
      SCAN:    if (w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_central   <= '0;
      r_radius    <= '0;
      r_mode      <= '0;
      r_x         <= FIRST;
      r_y         <= FIRST;
      r_cnt       <= '0;
      r_candidate <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_valid <= 1'b0;
      if (w_start) begin
        r_central <= bus.central;
        r_radius  <= bus.radius;
        r_mode    <= bus.mode;
        r_cnt     <= '0;
        r_x       <= FIRST;
        r_y       <= FIRST;
      end else if (r_state == SCAN) begin
        r_cnt <= r_cnt + CNT_W'(w_hit);
        // Raster advance; the wrap after the last point leaves x=y=1.
        if (r_x == LAST) begin
          r_x <= FIRST;
          r_y <= (r_y == LAST) ? FIRST : r_y + FIRST;
        end else begin
          r_x <= r_x + FIRST;
        end
        if (w_last) begin
          r_candidate <= r_cnt + CNT_W'(w_hit);
          r_valid     <= 1'b1;
        end
      end
    end
  end

  assign bus.busy      = (r_state == SCAN);
  assign bus.valid     = r_valid;
  assign bus.candidate = r_candidate;

endmodule

// File: doc/set_multi_circle.md
Name: set_multi_circle

Overview:
Parametrised successor to the 8x8 two-circle set counter. Scans a GRID x GRID lattice of integer points (1..GRID on each axis) against three circles A, B and C. For each point it counts those that satisfy a mode-selected set predicate, and returns the count through a busy/valid handshake. All predicates are evaluated in a single pass at one point per cycle, replacing the three-pass scheme; union, triple-intersection and exactly-two modes are new.

Parameters:
- GRID, 8: lattice side; points (x,y) with x,y in 1..GRID; legal range 2..(2^CW)-1.
- CW, 4: coordinate and radius field width in bits.
- CNT_W, derived: clog2(GRID*GRID+1); width of the count and of `candidate`.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous active-high reset.
- en, input, 1: job start; sampled only when busy=0.
- central, input, 6*CW: {Ax,Ay,Bx,By,Cx,Cy}, MSB first; unsigned; a centre may lie off-grid (0 or >GRID).
- radius, input, 3*CW: {rA,rB,rC}, MSB first; unsigned.
- mode, input, 3: predicate select (see Behaviour).
- busy, output, 1: high while a job is in progress; en is ignored while high.
- valid, output, 1: one-cycle pulse; `candidate` is valid during it.
- candidate, output, CNT_W: count result; holds its value until the next result or reset.

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). On rst: state=IDLE, busy=0, valid=0, candidate=0, counter=0, x=y=1, captured registers=0.
- FSM states and transitions:
  - IDLE to SCAN when en=1.
  - SCAN to IDLE on the last point (x=GRID, y=GRID).
  - busy = (state==SCAN), decoded from the state register.
- Capture: in cycle T with state=IDLE and en=1, latch central, radius and mode; clear counter; set x=y=1. Input changes after T have no effect on the job.
- Scan:
  - One point per cycle, cycles T+1 .. T+GRID^2.
  - Raster order: x increments 1..GRID, then wraps to 1 and y increments.
- Membership: inK = (|x-Kx|^2 + |y-Ky|^2 <= rK^2), inclusive boundary.
  - Absolute differences use CW bits; squares use 2CW bits; the sum uses 2CW+1 bits; no truncation.
  - rK=0 matches the centre point only, and only when the centre is on-grid.
- Mode predicates, evaluated per point:
  - 0: A
  - 1: A&B
  - 2: A^B
  - 3: exactly two of A,B,C
  - 4: A&B&C
  - 5: A|B|C
  - 6, 7: reserved; predicate is always false, so the result is 0.
- Count: counter += hit each SCAN cycle. On the last SCAN cycle, candidate <= counter+hit and valid <= 1.
- Output timing: valid is high in cycle T+GRID^2+1; state is IDLE and busy=0 in that same cycle. Latency from en to valid is GRID^2+1 cycles.
- Back-to-back jobs: en=1 in the valid cycle is accepted. The next result arrives GRID^2+1 cycles later.
- en while busy: ignored; no effect on capture, counter or outputs.
- rst mid-scan: the job is aborted with no valid pulse, and candidate is cleared to 0. busy=0 from the next cycle.
- Counter cannot overflow: the maximum count is GRID^2, which fits in CNT_W.

Decomposition:
- Package set_pkg:
  - Mode encodings: MODE_A, MODE_AND, MODE_XOR, MODE_TWO, MODE_AND3, MODE_OR3.
  - FSM state enum: IDLE, SCAN.
  - clog2-based CNT_W function.
- Sub-module set_circle_hit: combinational point-in-circle test, parametrised on CW. Inputs: point, centre, radius. Output: in. Instantiated three times (A, B, C).
- The top level holds the FSM, the x/y scan counters, the predicate mux and the accumulator.

Test Plan:
1. GRID=8, mode 0, A=(4,4) rA=2, en pulse at cycle T -> busy high T+1..T+64; valid single pulse at T+65; candidate=13.
2. Mode 1, A=(3,3) r2, B=(5,3) r2 -> candidate=5. Same circles, mode 2 -> candidate=16.
3. Mode 4, A=(3,3) r2, B=(5,3) r2, C=(4,4) r1 -> candidate=2. Mode 5 with A=B=C=(4,4) r2 -> candidate=13.
4. Edge clipping: mode 0, A=(1,1) r2 -> candidate=6. A=(0,0) r0 -> candidate=0. Mode 6 with any input -> candidate=0 and valid still pulses.
5. Change central and mode while busy and pulse en mid-scan -> result matches the inputs captured at T, and no extra job starts.
6. Assert rst at scan cycle 30 -> no valid pulse, candidate=0, busy=0 next cycle. Then run test 1, with en in its valid cycle starting test 2 -> both results correct, valid pulses 65 cycles apart.
